// File: rtl/alu_op_dispatcher.sv
// Command front-end for the four registered ALU sub-units: latches one operation,
// pulses the selected unit enable for one cycle and captures that unit's result.
module alu_op_dispatcher #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [WIDTH-1:0] CMD_A,
    input  logic [WIDTH-1:0] CMD_B,
    input  logic [3:0]       CMD_FUN,
    output logic [WIDTH-1:0] UNIT_A,
    output logic [WIDTH-1:0] UNIT_B,
    output logic [1:0]       UNIT_FUN,
    output logic             ARITH_EN,
    output logic             LOGIC_EN,
    output logic             CMP_EN,
    output logic             SHIFT_EN,
    input  logic [WIDTH-1:0] ARITH_OUT,
    input  logic [WIDTH-1:0] LOGIC_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] SHIFT_OUT,
    input  logic             ARITH_FLAG,
    input  logic             LOGIC_FLAG,
    input  logic             CMP_FLAG,
    input  logic             SHIFT_FLAG,
    output logic [WIDTH-1:0] RES_OUT,
    output logic [1:0]       RES_UNIT,
    output logic             RES_ERR,
    output logic             RES_VALID,
    input  logic             RES_READY
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       fun_q, fun_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       res_unit_q, res_unit_d;
    logic             res_err_q, res_err_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;

    logic             sel_flag_c;
    logic [WIDTH-1:0] sel_out_c;

    // Result/flag of the unit chosen by the latched function code
    always_comb begin
        sel_flag_c = 1'b0;
        sel_out_c  = '0;
        case (fun_q[3:2])
            2'd0: begin sel_flag_c = ARITH_FLAG; sel_out_c = ARITH_OUT; end
            2'd1: begin sel_flag_c = LOGIC_FLAG; sel_out_c = LOGIC_OUT; end
            2'd2: begin sel_flag_c = CMP_FLAG;   sel_out_c = CMP_OUT;   end
            default: begin sel_flag_c = SHIFT_FLAG; sel_out_c = SHIFT_OUT; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        res_d       = res_q;
        res_unit_d  = res_unit_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        en_d        = 4'b0000;
        cnt_d       = cnt_q;
        rdy_d       = rdy_q;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    a_d     = CMD_A;
                    b_d     = CMD_B;
                    fun_d   = CMD_FUN;
                    en_d    = 4'(4'b0001 << CMD_FUN[3:2]);
                    rdy_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Error result once the last allowed WAIT cycle passes without the flag
                if (sel_flag_c) begin
                    res_d       = sel_out_c;
                    res_unit_d  = fun_q[3:2];
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    res_d       = '0;
                    res_unit_d  = fun_q[3:2];
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    rdy_d       = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            res_q       <= '0;
            res_unit_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            en_q        <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            res_q       <= res_d;
            res_unit_q  <= res_unit_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
        end
    end

    assign CMD_READY = rdy_q;
    assign UNIT_A    = a_q;
    assign UNIT_B    = b_q;
    assign UNIT_FUN  = fun_q[1:0];
    assign ARITH_EN  = en_q[0];
    assign LOGIC_EN  = en_q[1];
    assign CMP_EN    = en_q[2];
    assign SHIFT_EN  = en_q[3];
    assign RES_OUT   = res_q;
    assign RES_UNIT  = res_unit_q;
    assign RES_ERR   = res_err_q;
    assign RES_VALID = res_valid_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Bench for alu_op_dispatcher: sub-unit models, a latency-based reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_alu_op_dispatcher;

    localparam int W  = 16;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CMD_VALID, CMD_READY;
    logic [W-1:0]  CMD_A, CMD_B;
    logic [3:0]    CMD_FUN;
    logic [W-1:0]  UNIT_A, UNIT_B;
    logic [1:0]    UNIT_FUN;
    logic          ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic [W-1:0]  ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
    logic          ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
    logic [W-1:0]  RES_OUT;
    logic [1:0]    RES_UNIT;
    logic          RES_ERR, RES_VALID, RES_READY;

    int n_chk  = 0;
    int n_fail = 0;
    logic run_cmp = 1'b0;

    always #5 CLK = ~CLK;

    alu_op_dispatcher #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
        .UNIT_A(UNIT_A), .UNIT_B(UNIT_B), .UNIT_FUN(UNIT_FUN),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
        .RES_OUT(RES_OUT), .RES_UNIT(RES_UNIT), .RES_ERR(RES_ERR),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour of the four ALU sub-units
    function automatic logic [W-1:0] unit_fn(input int u, input logic [1:0] f,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (u)
            0: case (f) 2'd0: r = a + b; 2'd1: r = a - b; 2'd2: r = a; default: r = -a; endcase
            1: case (f) 2'd0: r = a & b; 2'd1: r = a | b; 2'd2: r = a ^ b; default: r = ~(a | b); endcase
            2: case (f)
                   2'd0: r = W'($signed(a) < $signed(b));
                   2'd1: r = W'(a == b);
                   2'd2: r = W'(a < b);
                   default: r = W'($signed(a) > $signed(b));
               endcase
            default: case (f)
                   2'd0: r = a << b[3:0];
                   2'd1: r = a >> b[3:0];
                   2'd2: r = W'($signed(a) >>> b[3:0]);
                   default: r = (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
               endcase
        endcase
        return r;
    endfunction

    logic [3:0]   never_flag = '0;
    logic [3:0]   inj_flag = '0;
    logic [W-1:0] inj_out [4];
    logic [3:0]   u_flag;
    logic [W-1:0] u_out [4];
    logic [3:0]   u_en;

    assign u_en = {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN};

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            u_flag <= '0;
            for (int i = 0; i < 4; i++) u_out[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                u_flag[i] <= u_en[i] && !never_flag[i];
                u_out[i]  <= u_en[i] ? unit_fn(i, UNIT_FUN, UNIT_A, UNIT_B) : '0;
            end
        end
    end

    assign ARITH_FLAG = u_flag[0] | inj_flag[0];
    assign LOGIC_FLAG = u_flag[1] | inj_flag[1];
    assign CMP_FLAG   = u_flag[2] | inj_flag[2];
    assign SHIFT_FLAG = u_flag[3] | inj_flag[3];
    assign ARITH_OUT  = inj_flag[0] ? inj_out[0] : u_out[0];
    assign LOGIC_OUT  = inj_flag[1] ? inj_out[1] : u_out[1];
    assign CMP_OUT    = inj_flag[2] ? inj_out[2] : u_out[2];
    assign SHIFT_OUT  = inj_flag[3] ? inj_out[3] : u_out[3];

    // Reference model: edges elapsed since acceptance decide what happens
    logic         m_busy, m_hold, m_err, m_valid;
    int           m_age;
    logic [W-1:0] m_a, m_b, m_res;
    logic [3:0]   m_fun;
    logic [1:0]   m_unit;

    always @(posedge CLK or negedge RST) begin
        logic [3:0]   fl;
        logic [W-1:0] ov [4];
        int           u;
        fl = {SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG};
        ov[0] = ARITH_OUT; ov[1] = LOGIC_OUT; ov[2] = CMP_OUT; ov[3] = SHIFT_OUT;
        if (!RST) begin
            m_busy = 0; m_hold = 0; m_err = 0; m_valid = 0; m_age = 0;
            m_a = '0; m_b = '0; m_res = '0; m_fun = '0; m_unit = '0;
        end else if (!m_busy) begin
            if (CMD_VALID) begin
                m_a = CMD_A; m_b = CMD_B; m_fun = CMD_FUN;
                m_busy = 1; m_hold = 0; m_age = 0;
            end
        end else if (m_hold) begin
            if (RES_READY) begin
                m_valid = 0; m_busy = 0; m_hold = 0;
            end
        end else begin
            m_age++;
            if (m_age >= 2) begin
                u = int'(m_fun[3:2]);
                if (fl[u]) begin
                    m_res = ov[u]; m_err = 0; m_unit = m_fun[3:2]; m_valid = 1; m_hold = 1;
                end else if (m_age - 2 == TO - 1) begin
                    m_res = '0; m_err = 1; m_unit = m_fun[3:2]; m_valid = 1; m_hold = 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RST && run_cmp) begin
            chk("cmd_ready", 32'(CMD_READY), 32'(!m_busy));
            chk("enables", 32'({SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN}),
                32'((m_busy && !m_hold && m_age == 0) ? (4'b0001 << m_fun[3:2]) : 4'b0000));
            chk("unit_a", 32'(UNIT_A), 32'(m_a));
            chk("unit_b", 32'(UNIT_B), 32'(m_b));
            chk("unit_fun", 32'(UNIT_FUN), 32'(m_fun[1:0]));
            chk("res_valid", 32'(RES_VALID), 32'(m_valid));
            chk("res_out", 32'(RES_OUT), 32'(m_res));
            chk("res_unit", 32'(RES_UNIT), 32'(m_unit));
            chk("res_err", 32'(RES_ERR), 32'(m_err));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        CMD_VALID = 1'b1; CMD_FUN = f; CMD_A = a; CMD_B = b;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!RES_VALID && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_res_valid", 32'(RES_VALID), 32'd1);
    endtask

    initial begin
        int ar, cp, cp_idx;
        logic [W-1:0] got0, got2;
        for (int i = 0; i < 4; i++) inj_out[i] = '0;
        CMD_VALID = 0; CMD_A = '0; CMD_B = '0; CMD_FUN = '0; RES_READY = 0;
        repeat (3) tick();
        #2 RST = 1'b1;
        tick();
        run_cmp = 1'b1;
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_res_out", 32'(RES_OUT), 32'd0);
        chk("rst_enables", 32'({SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN}), 32'd0);

        // Logic AND with immediate consumption
        RES_READY = 1;
        issue(4'b0100, 16'h00F0, 16'h0FF0);
        tick(); CMD_VALID = 0;
        chk("and_logic_en", 32'(LOGIC_EN), 32'd1);
        chk("and_unit_fun", 32'(UNIT_FUN), 32'd0);
        chk("and_cmd_ready", 32'(CMD_READY), 32'd0);
        tick();
        chk("and_logic_en_off", 32'(LOGIC_EN), 32'd0);
        chk("and_not_yet_valid", 32'(RES_VALID), 32'd0);
        tick();
        chk("and_valid", 32'(RES_VALID), 32'd1);
        chk("and_res_out", 32'(RES_OUT), 32'h00F0);
        chk("and_res_unit", 32'(RES_UNIT), 32'd1);
        chk("and_res_err", 32'(RES_ERR), 32'd0);
        tick();
        chk("and_released", 32'(RES_VALID), 32'd0);
        chk("and_ready_back", 32'(CMD_READY), 32'd1);

        // Backpressure on the result
        RES_READY = 0;
        issue(4'b0111, 16'h0005, 16'h000A);
        tick(); CMD_VALID = 0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(RES_VALID), 32'd1);
            chk("bp_res_out", 32'(RES_OUT), 32'hFFF0);
            chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
            tick();
        end
        RES_READY = 1;
        tick();
        chk("bp_released", 32'(RES_VALID), 32'd0);
        chk("bp_ready_back", 32'(CMD_READY), 32'd1);

        // Back-to-back commands with CMD_VALID held high
        issue(4'b0001, 16'h0003, 16'h0005);
        tick();
        issue(4'b1000, 16'hFFFE, 16'h0001);
        ar = 0; cp = 0; cp_idx = -1; got0 = '0; got2 = '0;
        for (int i = 0; i < 9; i++) begin
            if (ARITH_EN) ar++;
            if (CMP_EN) begin
                cp++;
                if (cp_idx < 0) cp_idx = i;
                CMD_VALID = 0;
            end
            if (RES_VALID && RES_UNIT == 2'd0) got0 = RES_OUT;
            if (RES_VALID && RES_UNIT == 2'd2) got2 = RES_OUT;
            tick();
        end
        chk("b2b_arith_pulses", 32'(ar), 32'd1);
        chk("b2b_cmp_pulses", 32'(cp), 32'd1);
        chk("b2b_cmp_issue_cycle", 32'(cp_idx), 32'd4);
        chk("b2b_arith_result", 32'(got0), 32'hFFFE);
        chk("b2b_cmp_result", 32'(got2), 32'h0001);

        // Selected unit never answers
        never_flag[2] = 1;
        issue(4'b1001, 16'h0007, 16'h0007);
        tick(); CMD_VALID = 0;
        repeat (4) tick();
        chk("to_not_yet_valid", 32'(RES_VALID), 32'd0);
        tick();
        chk("to_valid", 32'(RES_VALID), 32'd1);
        chk("to_err", 32'(RES_ERR), 32'd1);
        chk("to_res_out", 32'(RES_OUT), 32'd0);
        chk("to_res_unit", 32'(RES_UNIT), 32'd2);
        tick();
        never_flag[2] = 0;

        // Stray flag from a non-selected unit
        never_flag[1] = 1;
        issue(4'b0110, 16'h0001, 16'h0002);
        tick(); CMD_VALID = 0;
        tick();
        inj_out[3] = 16'hBEEF; inj_flag[3] = 1;
        tick();
        chk("stray_ignored", 32'(RES_VALID), 32'd0);
        inj_flag[3] = 0;
        inj_out[1] = 16'h1234; inj_flag[1] = 1;
        tick();
        inj_flag[1] = 0;
        chk("stray_valid", 32'(RES_VALID), 32'd1);
        chk("stray_res_out", 32'(RES_OUT), 32'h1234);
        chk("stray_res_unit", 32'(RES_UNIT), 32'd1);
        tick();
        never_flag[1] = 0;

        // Reset while waiting
        never_flag[0] = 1;
        issue(4'b0000, 16'h0001, 16'h0001);
        tick(); CMD_VALID = 0;
        tick();
        #2 RST = 1'b0;
        #1;
        chk("rst_mid_enables", 32'({SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN}), 32'd0);
        chk("rst_mid_valid", 32'(RES_VALID), 32'd0);
        tick();
        #2 RST = 1'b1;
        never_flag[0] = 0;
        for (int i = 0; i < TO + 6; i++) begin
            tick();
            chk("rst_abort_no_result", 32'(RES_VALID), 32'd0);
            chk("rst_abort_ready", 32'(CMD_READY), 32'd1);
        end

        // Recovery after reset
        issue(4'b1100, 16'h0003, 16'h0004);
        tick(); CMD_VALID = 0;
        wait_valid(10);
        chk("post_rst_res_out", 32'(RES_OUT), 32'h0030);
        chk("post_rst_res_unit", 32'(RES_UNIT), 32'd3);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
